// File: rtl/rob_commit.sv
// rob_commit: 8-entry reorder buffer with in-order, one-per-cycle retirement.
//
// Issue allocates entries at the tail and receives the tail index as the
// instruction tag. The CDB marks entries done and stores their result. The
// head entry retires once it is both busy and done. Each retirement registers
// a one-cycle commit pulse and a register-bank write. Branches never write
// the bank. commit_unit tells issue which reservation-station class to release.
//
// Optional feature, enabled by defining ROB_FLUSH_EN:
//   adds cdb_mispredict / flush. A branch entry that completed with the
//   mispredict flag set flushes the whole buffer when it retires.
//
// Ports:
//   clk1, rst_n              clock (rising edge), async active-low reset
//   alloc_valid/rd/unit      allocation request from issue
//   alloc_ready, alloc_tag   entry available / tag the entry would receive
//   cdb_valid/tag/value      result broadcast
//   cdb_mispredict, flush    (ROB_FLUSH_EN only) branch mispredict in / flush out
//   commit_valid/unit/tag    registered retirement pulse
//   rf_we/waddr/wdata        registered register-bank write
//   rob_count/empty/full     occupancy status
module rob_commit #(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned PTR_W  = 3
) (
  input  logic              clk1,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [REG_W-1:0]  alloc_rd,
  input  logic [1:0]        alloc_unit,
  output logic              alloc_ready,
  output logic [PTR_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [PTR_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_value,
`ifdef ROB_FLUSH_EN
  input  logic              cdb_mispredict,
  output logic              flush,
`endif
  output logic              commit_valid,
  output logic [1:0]        commit_unit,
  output logic [PTR_W-1:0]  commit_tag,
  output logic              rf_we,
  output logic [REG_W-1:0]  rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  output logic [PTR_W:0]    rob_count,
  output logic              rob_empty,
  output logic              rob_full
);

  localparam int unsigned CNT_W    = PTR_W + 1;
  localparam logic [1:0]  UNIT_ADD = 2'd0;
  localparam logic [1:0]  UNIT_BCH = 2'd2;

  // Entry state: busy/done carry reset, payload does not need to.
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DEPTH-1:0]  done_q, done_d;
  logic [REG_W-1:0]  rd_q    [DEPTH];
  logic [1:0]        unit_q  [DEPTH];
  logic [DATA_W-1:0] value_q [DEPTH];

  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;

  // Registered retirement outputs.
  logic              commit_valid_q, commit_valid_d;
  logic [1:0]        commit_unit_q, commit_unit_d;
  logic [PTR_W-1:0]  commit_tag_q, commit_tag_d;
  logic              rf_we_q, rf_we_d;
  logic [REG_W-1:0]  rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;

  logic              alloc_ok_c;
  logic              alloc_do_c;
  logic              cdb_hit_c;
  logic              commit_fire_c;
  logic              flush_fire_c;
  logic [1:0]        alloc_unit_c;

  // Decisions from pre-edge state only.
  assign alloc_ok_c    = (count_q < CNT_W'(DEPTH));
  assign cdb_hit_c     = cdb_valid && busy_q[cdb_tag] && !done_q[cdb_tag];
  assign commit_fire_c = busy_q[head_q] && done_q[head_q];
  // Reserved unit code 3 is stored as add so release accounting sees add.
  assign alloc_unit_c  = (alloc_unit == 2'd3) ? UNIT_ADD : alloc_unit;

`ifdef ROB_FLUSH_EN
  logic [DEPTH-1:0] mis_q;
  logic             flush_q, flush_d;

  assign flush_fire_c = commit_fire_c && mis_q[head_q] && (unit_q[head_q] == UNIT_BCH);
  assign flush        = flush_q;
`else
  assign flush_fire_c = 1'b0;
`endif

  // A flushing retirement drops any allocation in the same cycle.
  assign alloc_do_c = alloc_valid && alloc_ok_c && !flush_fire_c;

  // Next-state for pointers, occupancy and entry flags.
  always_comb begin
    busy_d  = busy_q;
    done_d  = done_q;
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;

    if (cdb_hit_c) begin
      done_d[cdb_tag] = 1'b1;
    end
    if (commit_fire_c) begin
      busy_d[head_q] = 1'b0;
      done_d[head_q] = 1'b0;
      head_d         = head_q + PTR_W'(1);
    end
    if (alloc_do_c) begin
      busy_d[tail_q] = 1'b1;
      done_d[tail_q] = 1'b0;
      tail_d         = tail_q + PTR_W'(1);
    end

    unique case ({alloc_do_c, commit_fire_c})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    if (flush_fire_c) begin
      busy_d  = '0;
      done_d  = '0;
      tail_d  = head_q + PTR_W'(1);
      count_d = '0;
    end
  end

  // Next values of the registered retirement outputs; address/data hold when idle.
  always_comb begin
    commit_valid_d = 1'b0;
    commit_unit_d  = commit_unit_q;
    commit_tag_d   = commit_tag_q;
    rf_we_d        = 1'b0;
    rf_waddr_d     = rf_waddr_q;
    rf_wdata_d     = rf_wdata_q;
    if (commit_fire_c) begin
      commit_valid_d = 1'b1;
      commit_unit_d  = unit_q[head_q];
      commit_tag_d   = head_q;
      rf_we_d        = (unit_q[head_q] != UNIT_BCH);
      rf_waddr_d     = rd_q[head_q];
      rf_wdata_d     = value_q[head_q];
    end
  end

`ifdef ROB_FLUSH_EN
  always_comb begin
    flush_d = flush_fire_c;
  end
`endif

  // Control and output registers.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      busy_q         <= '0;
      done_q         <= '0;
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      commit_valid_q <= 1'b0;
      commit_unit_q  <= '0;
      commit_tag_q   <= '0;
      rf_we_q        <= 1'b0;
      rf_waddr_q     <= '0;
      rf_wdata_q     <= '0;
    end else begin
      busy_q         <= busy_d;
      done_q         <= done_d;
      head_q         <= head_d;
      tail_q         <= tail_d;
      count_q        <= count_d;
      commit_valid_q <= commit_valid_d;
      commit_unit_q  <= commit_unit_d;
      commit_tag_q   <= commit_tag_d;
      rf_we_q        <= rf_we_d;
      rf_waddr_q     <= rf_waddr_d;
      rf_wdata_q     <= rf_wdata_d;
    end
  end

`ifdef ROB_FLUSH_EN
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      flush_q <= 1'b0;
    end else begin
      flush_q <= flush_d;
    end
  end
`endif

  // Entry payload; valid only while the busy/done flags say so.
  always_ff @(posedge clk1) begin
    if (alloc_do_c) begin
      rd_q[tail_q]   <= alloc_rd;
      unit_q[tail_q] <= alloc_unit_c;
    end
    if (cdb_hit_c) begin
      value_q[cdb_tag] <= cdb_value;
`ifdef ROB_FLUSH_EN
      mis_q[cdb_tag]   <= cdb_mispredict && (unit_q[cdb_tag] == UNIT_BCH);
`endif
    end
  end

  assign alloc_ready  = alloc_ok_c;
  assign alloc_tag    = tail_q;
  assign rob_count    = count_q;
  assign rob_empty    = (count_q == '0);
  assign rob_full     = (count_q == CNT_W'(DEPTH));
  assign commit_valid = commit_valid_q;
  assign commit_unit  = commit_unit_q;
  assign commit_tag   = commit_tag_q;
  assign rf_we        = rf_we_q;
  assign rf_waddr     = rf_waddr_q;
  assign rf_wdata     = rf_wdata_q;

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: a queue-of-instructions model predicts
// retirements; a monitor compares them against the DUT one cycle later.
module tb_rob_commit;

  localparam int DEPTH = 8;

`ifdef ROB_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        alloc_valid;
  logic [3:0]  alloc_rd;
  logic [1:0]  alloc_unit;
  logic        alloc_ready;
  logic [2:0]  alloc_tag;
  logic        cdb_valid;
  logic [2:0]  cdb_tag;
  logic [15:0] cdb_value;
  logic        commit_valid;
  logic [1:0]  commit_unit;
  logic [2:0]  commit_tag;
  logic        rf_we;
  logic [3:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic [3:0]  rob_count;
  logic        rob_empty;
  logic        rob_full;
`ifdef ROB_FLUSH_EN
  logic        cdb_mispredict;
  logic        flush;
`endif

  rob_commit dut (
    .clk1        (clk1),
    .rst_n       (rst_n),
    .alloc_valid (alloc_valid),
    .alloc_rd    (alloc_rd),
    .alloc_unit  (alloc_unit),
    .alloc_ready (alloc_ready),
    .alloc_tag   (alloc_tag),
    .cdb_valid   (cdb_valid),
    .cdb_tag     (cdb_tag),
    .cdb_value   (cdb_value),
`ifdef ROB_FLUSH_EN
    .cdb_mispredict (cdb_mispredict),
    .flush          (flush),
`endif
    .commit_valid (commit_valid),
    .commit_unit  (commit_unit),
    .commit_tag   (commit_tag),
    .rf_we        (rf_we),
    .rf_waddr     (rf_waddr),
    .rf_wdata     (rf_wdata),
    .rob_count    (rob_count),
    .rob_empty    (rob_empty),
    .rob_full     (rob_full)
  );

  always #5 clk1 = ~clk1;

  typedef struct {
    int tag;
    int rd;
    int unit;
    bit done;
    int value;
    bit mis;
  } ent_t;

  typedef struct {
    int unit;
    int tag;
    bit we;
    int rd;
    int value;
    bit fl;
  } exp_t;

  ent_t rob_m[$];   // in-flight instructions, oldest first
  exp_t exp_q[$];   // retirements expected after the next edge
  int   tail_m;
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: check status against the model, drive inputs, advance the model.
  task automatic step(input bit av, input int rd, input int unit,
                      input bit cv, input int ctag, input int cval, input bit mp);
    ent_t e;
    exp_t x;
    bit   commit;
    bit   fl;
    int   pre_size;
    @(negedge clk1);
    chk("rob_count", int'(rob_count), rob_m.size());
    chk("alloc_ready", int'(alloc_ready), int'(rob_m.size() < DEPTH));
    chk("alloc_tag", int'(alloc_tag), tail_m);
    chk("rob_empty", int'(rob_empty), int'(rob_m.size() == 0));
    chk("rob_full", int'(rob_full), int'(rob_m.size() == DEPTH));
    alloc_valid = av;
    alloc_rd    = 4'(rd);
    alloc_unit  = 2'(unit);
    cdb_valid   = cv;
    cdb_tag     = 3'(ctag);
    cdb_value   = 16'(cval);
`ifdef ROB_FLUSH_EN
    cdb_mispredict = mp;
`endif
    pre_size = rob_m.size();
    commit   = (pre_size > 0) && rob_m[0].done;
    if (cv) begin
      foreach (rob_m[i]) begin
        if (rob_m[i].tag == ctag && !rob_m[i].done) begin
          rob_m[i].done  = 1'b1;
          rob_m[i].value = cval;
          rob_m[i].mis   = mp && (rob_m[i].unit == 2);
        end
      end
    end
    fl = 1'b0;
    if (commit) begin
      e       = rob_m.pop_front();
      fl      = FLUSH_ON && (e.unit == 2) && e.mis;
      x.unit  = e.unit;
      x.tag   = e.tag;
      x.we    = (e.unit != 2);
      x.rd    = e.rd;
      x.value = e.value;
      x.fl    = fl;
      exp_q.push_back(x);
    end
    if (fl) begin
      rob_m.delete();
      tail_m = (e.tag + 1) % DEPTH;
    end else if (av && pre_size < DEPTH) begin
      e.tag   = tail_m;
      e.rd    = rd;
      e.unit  = (unit == 3) ? 0 : unit;
      e.done  = 1'b0;
      e.value = 0;
      e.mis   = 1'b0;
      rob_m.push_back(e);
      tail_m = (tail_m + 1) % DEPTH;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    @(negedge clk1);
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    cdb_valid   = 1'b0;
`ifdef ROB_FLUSH_EN
    cdb_mispredict = 1'b0;
`endif
    #1;
    chk("rst_alloc_ready", int'(alloc_ready), 1);
    chk("rst_alloc_tag", int'(alloc_tag), 0);
    chk("rst_rob_count", int'(rob_count), 0);
    chk("rst_rob_empty", int'(rob_empty), 1);
    chk("rst_rob_full", int'(rob_full), 0);
    chk("rst_commit_valid", int'(commit_valid), 0);
    chk("rst_rf_we", int'(rf_we), 0);
    rob_m.delete();
    exp_q.delete();
    tail_m = 0;
    repeat (2) @(negedge clk1);
    rst_n = 1'b1;
  endtask

  // Monitor: every expected retirement must appear right after its edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk1);
      #1;
      chk("commit_valid", int'(commit_valid), int'(exp_q.size() > 0));
      if (commit_valid && exp_q.size() > 0) begin
        x = exp_q.pop_front();
        chk("commit_unit", int'(commit_unit), x.unit);
        chk("commit_tag", int'(commit_tag), x.tag);
        chk("rf_we", int'(rf_we), int'(x.we));
        if (x.we) begin
          chk("rf_waddr", int'(rf_waddr), x.rd);
          chk("rf_wdata", int'(rf_wdata), x.value);
        end
`ifdef ROB_FLUSH_EN
        chk("flush", int'(flush), int'(x.fl));
`endif
      end else begin
        if (exp_q.size() > 0) void'(exp_q.pop_front());
        chk("rf_we_idle", int'(rf_we), 0);
`ifdef ROB_FLUSH_EN
        chk("flush_idle", int'(flush), 0);
`endif
      end
    end
  end

  initial begin
    int t;
    rst_n       = 1'b0;
    alloc_valid = 1'b0;
    alloc_rd    = '0;
    alloc_unit  = '0;
    cdb_valid   = 1'b0;
    cdb_tag     = '0;
    cdb_value   = '0;
`ifdef ROB_FLUSH_EN
    cdb_mispredict = 1'b0;
`endif
    tail_m = 0;
    do_reset();

    // Fill to full, then extra requests are ignored.
    for (int i = 0; i < DEPTH; i++) step(1, i, 0, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0, 0);
    step(1, 9, 0, 0, 0, 0, 0);
    // Full with head completing: commit while allocation is refused.
    step(1, 9, 1, 1, 0, 16'h0abc, 0);
    step(1, 9, 1, 0, 0, 0, 0);
    step(1, 10, 1, 0, 0, 0, 0);
    for (int i = 1; i < DEPTH; i++) step(0, 0, 0, 1, i, 16'h1000 + i, 0);
    step(0, 0, 0, 1, 0, 16'h2000, 0);
    idle(4);

    // Reset in the middle of traffic.
    step(1, 3, 0, 0, 0, 0, 0);
    step(1, 4, 1, 1, tail_m - 1, 16'h0077, 0);
    step(1, 5, 0, 1, tail_m - 1, 16'h0078, 0);
    do_reset();

    // Out-of-order completion retires in order.
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 2, 16'h0033, 0);
    step(0, 0, 0, 1, 0, 16'h0011, 0);
    step(0, 0, 0, 1, 1, 16'h0022, 0);
    idle(4);

    // Wrap-around: tag 7 retires before the reused tag 0.
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, i, 1, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH - 1; i++) step(0, 0, 0, 1, i, 16'h0100 + i, 0);
    idle(DEPTH);
    step(1, 5, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 16'h5500, 0);
    step(0, 0, 0, 1, 7, 16'h7700, 0);
    idle(4);

    // Branch retires without a register write; reserved unit acts as add.
    t = tail_m;
    step(1, 6, 2, 0, 0, 0, 0);
    step(1, 7, 3, 1, t, 16'hbeef, 0);
    step(0, 0, 0, 1, (t + 1) % DEPTH, 16'h1234, 0);
    idle(4);

`ifdef ROB_FLUSH_EN
    // Mispredicted branch at head flushes everything.
    do_reset();
    step(1, 1, 2, 0, 0, 0, 0);
    step(1, 2, 0, 0, 0, 0, 0);
    step(1, 3, 1, 0, 0, 0, 0);
    step(1, 4, 0, 1, 1, 16'h0042, 0);
    step(0, 0, 0, 1, 0, 16'h0001, 1);
    step(1, 8, 0, 0, 0, 0, 0);
    idle(4);
`endif

    // Randomised traffic.
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 9) < 6, $urandom_range(0, 15), $urandom_range(0, 3),
           $urandom_range(0, 9) < 6, $urandom_range(0, DEPTH - 1),
           $urandom_range(0, 65535), FLUSH_ON && ($urandom_range(0, 3) == 0));
    end
    for (int n = 0; n < 40; n++) begin
      step(0, 0, 0, 1, n % DEPTH, $urandom_range(0, 65535), 0);
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
